digit_serial_adder: RTL and testbench

- Parametrised multi-cycle successor to the team's 4-bit ripple parallel adder.
- Adds or subtracts two WIDTH-bit operands DIGIT bits per clock through one DIGIT-bit ripple slice and a registered inter-digit carry.
- Trades latency for area. Uses valid/ready handshakes on both sides so it can sit between pipeline stages of the datapath.
- Reports carry-out and signed overflow.

---
 rtl/digit_serial_adder_if.sv | 27 ++
 rtl/digit_serial_adder.sv | 97 +++++++++
 tb/tb_digit_serial_adder.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/digit_serial_adder_if.sv
// Operand/result handshake bundle for the digit-serial adder.
// The master drives operands and out_ready; the slave (the adder) returns the result.
interface digit_serial_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, s, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, s, cout, ovf
  );
endinterface

// File: rtl/digit_serial_adder.sv
// Multi-cycle add/subtract: one DIGIT-bit ripple slice reused NUM_DIGITS times,
// with a registered inter-digit carry and valid/ready on both sides.
module digit_serial_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  digit_serial_adder_if.slave  bus,
  output logic [1:0]           dbg_state
);
  localparam int NUM_DIGITS = WIDTH / DIGIT;
  localparam int CNT_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  // Handshake: a transfer happens on a rising edge where valid && ready are both 1;
  // a source holds valid (and its data) until that edge, ready never waits on valid.
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q, s_q;
  logic             carry_q, cout_q, ovf_q;
  logic [CNT_W-1:0] cnt_q;

  logic [DIGIT-1:0] a_dig, b_dig, sum_dig;
  logic [DIGIT:0]   sum_ext;
  logic             c_next, c_into_msb, last_dig, accept;
  int               base;

  assign bus.in_ready  = (state == IDLE) && rst_n;
  assign bus.out_valid = (state == DONE);
  assign bus.s         = s_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
  assign dbg_state     = state;

  assign accept   = bus.in_valid && bus.in_ready;
  assign last_dig = (cnt_q == CNT_W'(NUM_DIGITS - 1));

  // Carry into the slice MSB is recovered from its sum bit, which keeps DIGIT=1 legal.
  always_comb begin
    base       = DIGIT * int'(cnt_q);
    a_dig      = a_q[base +: DIGIT];
    b_dig      = b_q[base +: DIGIT];
    sum_ext    = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT{1'b0}}, carry_q};
    sum_dig    = sum_ext[DIGIT-1:0];
    c_next     = sum_ext[DIGIT];
    c_into_msb = a_dig[DIGIT-1] ^ b_dig[DIGIT-1] ^ sum_dig[DIGIT-1];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (last_dig) state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_q     <= bus.a;
            b_q     <= bus.sub ? ~bus.b : bus.b;
            carry_q <= bus.sub ? ~bus.cin : bus.cin;
            cnt_q   <= '0;
          end
        end
        RUN: begin
          s_q[base +: DIGIT] <= sum_dig;
          carry_q            <= c_next;
          cnt_q              <= cnt_q + 1'b1;
          if (last_dig) begin
            cout_q <= c_next;
            ovf_q  <= c_into_msb ^ c_next;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_digit_serial_adder.sv
// Directed bench for digit_serial_adder at DIGIT = 4, 1 and 16 (WIDTH = 16).
module tb_digit_serial_adder;
  logic clk;
  logic rst_n;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  digit_serial_adder_if #(.WIDTH(16)) if4  ();
  digit_serial_adder_if #(.WIDTH(16)) if1  ();
  digit_serial_adder_if #(.WIDTH(16)) if16 ();

  logic [1:0] dbg4, dbg1, dbg16;

  digit_serial_adder #(.WIDTH(16), .DIGIT(4))  dut4  (.clk(clk), .rst_n(rst_n), .bus(if4.slave),  .dbg_state(dbg4));
  digit_serial_adder #(.WIDTH(16), .DIGIT(1))  dut1  (.clk(clk), .rst_n(rst_n), .bus(if1.slave),  .dbg_state(dbg1));
  digit_serial_adder #(.WIDTH(16), .DIGIT(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(if16.slave), .dbg_state(dbg16));

  // shared operand inputs, per-instance in_valid
  logic [15:0] a, b;
  logic        cin, sub, out_ready;
  logic        in_valid_v [3];
  logic        in_ready_v [3];
  logic        out_valid_v[3];
  logic [15:0] s_v        [3];
  logic        cout_v     [3];
  logic        ovf_v      [3];

  assign if4.a = a;   assign if4.b = b;   assign if4.cin = cin;   assign if4.sub = sub;
  assign if1.a = a;   assign if1.b = b;   assign if1.cin = cin;   assign if1.sub = sub;
  assign if16.a = a;  assign if16.b = b;  assign if16.cin = cin;  assign if16.sub = sub;
  assign if4.out_ready = out_ready;  assign if1.out_ready = out_ready;  assign if16.out_ready = out_ready;
  assign if4.in_valid  = in_valid_v[0];
  assign if1.in_valid  = in_valid_v[1];
  assign if16.in_valid = in_valid_v[2];

  assign in_ready_v[0] = if4.in_ready;   assign out_valid_v[0] = if4.out_valid;
  assign in_ready_v[1] = if1.in_ready;   assign out_valid_v[1] = if1.out_valid;
  assign in_ready_v[2] = if16.in_ready;  assign out_valid_v[2] = if16.out_valid;
  assign s_v[0] = if4.s;   assign cout_v[0] = if4.cout;   assign ovf_v[0] = if4.ovf;
  assign s_v[1] = if1.s;   assign cout_v[1] = if1.cout;   assign ovf_v[1] = if1.ovf;
  assign s_v[2] = if16.s;  assign cout_v[2] = if16.cout;  assign ovf_v[2] = if16.ovf;

  int pass_cnt  = 0;
  int check_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one operation into instance idx, waits for the result and checks it.
  task automatic run_op(input int idx, input string tag,
                        input logic [15:0] aa, input logic [15:0] bb,
                        input logic ci, input logic sb,
                        input logic [15:0] exp_s, input logic exp_c, input logic exp_o,
                        input int exp_lat);
    int lat;
    a = aa; b = bb; cin = ci; sub = sb;
    in_valid_v[idx] = 1'b1;
    check({tag, ".in_ready"}, 32'(in_ready_v[idx]), 32'd1);
    tick();
    in_valid_v[idx] = 1'b0;
    a = 16'hDEAD; b = 16'hBEEF; cin = ~ci; sub = ~sb;
    lat = 0;
    while (!out_valid_v[idx] && lat < 100) begin
      tick();
      lat++;
    end
    check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    check({tag, ".s"},       32'(s_v[idx]),    32'(exp_s));
    check({tag, ".cout"},    32'(cout_v[idx]), 32'(exp_c));
    check({tag, ".ovf"},     32'(ovf_v[idx]),  32'(exp_o));
    if (out_ready) begin
      tick();
      check({tag, ".out_valid_drop"}, 32'(out_valid_v[idx]), 32'd0);
    end
  endtask

  initial begin
    a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) in_valid_v[i] = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset%0d.s", i),         32'(s_v[i]),         32'd0);
      check($sformatf("reset%0d.out_valid", i), 32'(out_valid_v[i]), 32'd0);
      check($sformatf("reset%0d.in_ready", i),  32'(in_ready_v[i]),  32'd0);
    end
    rst_n = 1'b1;
    #1;
    check("reset.in_ready_release", 32'(in_ready_v[0]), 32'd1);

    // DIGIT=4 directed vectors
    run_op(0, "add_basic",   16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0, 4);
    run_op(0, "add_wrap",    16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 4);
    run_op(0, "add_ovf",     16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 4);
    run_op(0, "add_cin",     16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0, 4);
    run_op(0, "sub_neg",     16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 4);
    run_op(0, "sub_ovf",     16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 4);
    run_op(0, "sub_borrow",  16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000E, 1'b1, 1'b0, 4);

    // backpressure: hold result in DONE while a new request is offered
    out_ready = 1'b0;
    run_op(0, "bp", 16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0, 4);
    a = 16'h1111; b = 16'h2222; cin = 1'b0; sub = 1'b0;
    in_valid_v[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("bp%0d.out_valid", i), 32'(out_valid_v[0]), 32'd1);
      check($sformatf("bp%0d.in_ready", i),  32'(in_ready_v[0]),  32'd0);
      check($sformatf("bp%0d.s", i),         32'(s_v[0]),         32'h2233);
      check($sformatf("bp%0d.cout", i),      32'(cout_v[0]),      32'd0);
      check($sformatf("bp%0d.ovf", i),       32'(ovf_v[0]),       32'd0);
      check($sformatf("bp%0d.state", i),     32'(dbg4),           32'd2);
    end
    in_valid_v[0] = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp.release_out_valid", 32'(out_valid_v[0]), 32'd0);
    check("bp.release_state",     32'(dbg4),           32'd0);

    // reset in the second RUN cycle aborts the operation
    a = 16'h7FFF; b = 16'h0001; cin = 1'b0; sub = 1'b0;
    in_valid_v[0] = 1'b1;
    tick();
    in_valid_v[0] = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    check("rst_mid.s",         32'(s_v[0]),         32'd0);
    check("rst_mid.cout",      32'(cout_v[0]),      32'd0);
    check("rst_mid.ovf",       32'(ovf_v[0]),       32'd0);
    check("rst_mid.out_valid", 32'(out_valid_v[0]), 32'd0);
    check("rst_mid.in_ready_low", 32'(in_ready_v[0]), 32'd0);
    rst_n = 1'b1;
    #1;
    check("rst_mid.in_ready", 32'(in_ready_v[0]), 32'd1);
    begin
      int seen = 0;
      for (int i = 0; i < 8; i++) begin
        tick();
        if (out_valid_v[0]) seen++;
      end
      check("rst_mid.no_result", 32'(seen), 32'd0);
    end

    // bit-serial and single-cycle variants
    run_op(1, "d1_basic",  16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0, 16);
    run_op(1, "d1_ovf",    16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 16);
    run_op(2, "d16_basic", 16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0, 1);
    run_op(2, "d16_ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1);
    run_op(2, "d16_sub",   16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end
endmodule
